// File: rtl/bus_term_pkg.sv
// Shared types and defaults for the bus terminal buffer.
// Packet layout: destination ID in the top ID_W bits, payload below.
package bus_term_pkg;

  localparam int PCKG_SZ_D = 16;
  localparam int DEPTH_D   = 8;
  localparam int ID_W_D    = 8;

  typedef struct packed {
    logic [ID_W_D-1:0]           id;
    logic [PCKG_SZ_D-ID_W_D-1:0] payload;
  } pkt_t;

  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/sync_fwft_fifo.sv
// First-word fall-through FIFO with a separate occupancy count.
// Emits single-cycle overflow/underflow pulses for the owner to latch.
module sync_fwft_fifo
  import bus_term_pkg::*;
#(
  parameter int W     = 16,
  parameter int DEPTH = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    wr,
  input  logic [W-1:0]            wdata,
  input  logic                    rd,
  output logic [W-1:0]            rdata,
  output logic                    nempty,
  output logic                    full,
  output logic [cnt_w(DEPTH)-1:0] cnt,
  output logic                    acc,
  output logic                    ovf_p,
  output logic                    udf_p
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = cnt_w(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic          empty, rd_ok;

  assign empty  = (cnt == '0);
  assign full   = (cnt == CW'(DEPTH));
  assign nempty = !empty;

  // A read while full frees a slot in the same cycle.
  assign rd_ok = rd && !empty;
  assign acc   = wr && (!full || rd);
  assign ovf_p = wr && full && !rd;
  assign udf_p = rd && empty;

  assign rdata = empty ? '0 : mem[rp];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
    end else begin
      if (acc)   wp <= wp + 1'b1;
      if (rd_ok) rp <= rp + 1'b1;
      unique case ({acc, rd_ok})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (acc) mem[wp] <= wdata;
  end

endmodule

// File: rtl/bus_term_fifo.sv
// Per-terminal TX/RX buffer between host and one bus arbiter port.
// Optional destination-ID check enabled by BUS_TERM_ID_CHECK_EN.
module bus_term_fifo
  import bus_term_pkg::*;
#(
  parameter int PCKG_SZ = PCKG_SZ_D,
  parameter int DEPTH   = DEPTH_D,
  parameter int ID_W    = ID_W_D,
  parameter int TERM_ID = 0
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    wr_en,
  input  logic [PCKG_SZ-1:0]      wr_data,
  output logic                    tx_full,
  output logic [cnt_w(DEPTH)-1:0] tx_cnt,
  output logic                    pndng,
  output logic [PCKG_SZ-1:0]      D_pop,
  input  logic                    pop,
  input  logic                    push,
  input  logic [PCKG_SZ-1:0]      D_push,
  input  logic                    rx_rd,
  output logic [PCKG_SZ-1:0]      rx_data,
  output logic                    rx_vld,
  output logic [cnt_w(DEPTH)-1:0] rx_cnt,
  output logic                    ovf,
  output logic                    udf,
  output logic                    id_err,
  input  logic                    err_clr
);

  logic tx_acc, tx_ovf, tx_udf;
  logic rx_acc, rx_ovf, rx_udf;
  logic rx_full;

  sync_fwft_fifo #(.W(PCKG_SZ), .DEPTH(DEPTH)) u_tx (
    .clk   (clk),
    .rst   (reset),
    .wr    (wr_en),
    .wdata (wr_data),
    .rd    (pop),
    .rdata (D_pop),
    .nempty(pndng),
    .full  (tx_full),
    .cnt   (tx_cnt),
    .acc   (tx_acc),
    .ovf_p (tx_ovf),
    .udf_p (tx_udf)
  );

  sync_fwft_fifo #(.W(PCKG_SZ), .DEPTH(DEPTH)) u_rx (
    .clk   (clk),
    .rst   (reset),
    .wr    (push),
    .wdata (D_push),
    .rd    (rx_rd),
    .rdata (rx_data),
    .nempty(rx_vld),
    .full  (rx_full),
    .cnt   (rx_cnt),
    .acc   (rx_acc),
    .ovf_p (rx_ovf),
    .udf_p (rx_udf)
  );

  logic unused_acc;
  assign unused_acc = tx_acc ^ rx_full;

  // Set wins over err_clr in the same cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ovf <= 1'b0;
      udf <= 1'b0;
    end else begin
      ovf <= tx_ovf | rx_ovf | (ovf & ~err_clr);
      udf <= tx_udf | rx_udf | (udf & ~err_clr);
    end
  end

`ifdef BUS_TERM_ID_CHECK_EN
  logic id_set;
  assign id_set = rx_acc &&
    (D_push[PCKG_SZ-1 -: ID_W] != ID_W'(TERM_ID));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) id_err <= 1'b0;
    else       id_err <= id_set | (id_err & ~err_clr);
  end
`else
  logic unused_id;
  assign unused_id = ^{rx_acc, ID_W'(TERM_ID)};
  assign id_err    = 1'b0;
`endif

endmodule

// File: tb/tb_bus_term_fifo.sv
// Directed table-driven bench for bus_term_fifo.
// Covers FIFO order, full/empty boundaries, sticky flags, wrap, reset.
module tb_bus_term_fifo;
  import bus_term_pkg::*;

  localparam int PW = 16;
  localparam int DP = 8;
  localparam int IW = 8;
  localparam int CW = cnt_w(DP);

  logic          clk = 1'b0;
  logic          reset;
  logic          wr_en, pop, push, rx_rd, err_clr;
  logic [PW-1:0] wr_data, D_push;
  logic          tx_full, pndng, rx_vld, ovf, udf, id_err;
  logic [PW-1:0] D_pop, rx_data;
  logic [CW-1:0] tx_cnt, rx_cnt;

  always #5 clk = ~clk;

  bus_term_fifo #(
    .PCKG_SZ(PW), .DEPTH(DP), .ID_W(IW), .TERM_ID(3)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .wr_en  (wr_en),
    .wr_data(wr_data),
    .tx_full(tx_full),
    .tx_cnt (tx_cnt),
    .pndng  (pndng),
    .D_pop  (D_pop),
    .pop    (pop),
    .push   (push),
    .D_push (D_push),
    .rx_rd  (rx_rd),
    .rx_data(rx_data),
    .rx_vld (rx_vld),
    .rx_cnt (rx_cnt),
    .ovf    (ovf),
    .udf    (udf),
    .id_err (id_err),
    .err_clr(err_clr)
  );

  int errs = 0;
  int checks = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic idle();
    wr_en = 0; pop = 0; push = 0; rx_rd = 0; err_clr = 0;
    wr_data = '0; D_push = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic          wr;
    logic [PW-1:0] wd;
    logic          pp;
    logic          ps;
    logic [PW-1:0] dp;
    logic          rd;
    logic          clr;
    logic          e_pnd;
    logic [PW-1:0] e_dpop;
    logic [CW-1:0] e_tcnt;
    logic          e_full;
    logic          e_rvld;
    logic [PW-1:0] e_rdat;
    logic [CW-1:0] e_rcnt;
    logic          e_ovf;
    logic          e_udf;
  } vec_t;

  function automatic vec_t v(
    input int wr, wd, pp, ps, dp, rd, clr,
    input int pnd, dpop, tcnt, full, rvld, rdat, rcnt, o, u);
    vec_t r;
    r.wr = wr[0]; r.wd = wd[PW-1:0]; r.pp = pp[0];
    r.ps = ps[0]; r.dp = dp[PW-1:0]; r.rd = rd[0];
    r.clr = clr[0];
    r.e_pnd = pnd[0]; r.e_dpop = dpop[PW-1:0];
    r.e_tcnt = tcnt[CW-1:0]; r.e_full = full[0];
    r.e_rvld = rvld[0]; r.e_rdat = rdat[PW-1:0];
    r.e_rcnt = rcnt[CW-1:0]; r.e_ovf = o[0]; r.e_udf = u[0];
    return r;
  endfunction

  vec_t tv[17];
  logic [PW-1:0] q[$];
  logic [PW-1:0] exp_d;
  pkt_t pk;

  initial begin
    idle();
    reset = 1'b1;
    tick();
    tick();
    chk("rst_pndng", pndng, 0);
    chk("rst_dpop", D_pop, 0);
    chk("rst_tcnt", tx_cnt, 0);
    chk("rst_full", tx_full, 0);
    chk("rst_rvld", rx_vld, 0);
    chk("rst_rdata", rx_data, 0);
    chk("rst_flags", {ovf, udf, id_err}, 0);
    @(negedge clk);
    reset = 1'b0;
    tick();

    //      wr wd      pp ps dp      rd clr  pnd dpop    tc f rv rdat    rc o u
    tv[0]  = v(1, 'h0101, 0, 0, 0,      0, 0,   1, 'h0101, 1, 0, 0, 0,      0, 0, 0);
    tv[1]  = v(1, 'h0202, 0, 0, 0,      0, 0,   1, 'h0101, 2, 0, 0, 0,      0, 0, 0);
    tv[2]  = v(1, 'h0303, 0, 0, 0,      0, 0,   1, 'h0101, 3, 0, 0, 0,      0, 0, 0);
    tv[3]  = v(0, 0,      1, 0, 0,      0, 0,   1, 'h0202, 2, 0, 0, 0,      0, 0, 0);
    tv[4]  = v(0, 0,      1, 0, 0,      0, 0,   1, 'h0303, 1, 0, 0, 0,      0, 0, 0);
    tv[5]  = v(0, 0,      1, 0, 0,      0, 0,   0, 0,      0, 0, 0, 0,      0, 0, 0);
    tv[6]  = v(0, 0,      1, 0, 0,      0, 0,   0, 0,      0, 0, 0, 0,      0, 0, 1);
    tv[7]  = v(0, 0,      0, 0, 0,      0, 1,   0, 0,      0, 0, 0, 0,      0, 0, 0);
    tv[8]  = v(0, 0,      1, 0, 0,      0, 1,   0, 0,      0, 0, 0, 0,      0, 0, 1);
    tv[9]  = v(0, 0,      0, 0, 0,      0, 1,   0, 0,      0, 0, 0, 0,      0, 0, 0);
    tv[10] = v(1, 'h0AAA, 1, 0, 0,      0, 0,   1, 'h0AAA, 1, 0, 0, 0,      0, 0, 1);
    tv[11] = v(0, 0,      1, 0, 0,      0, 1,   0, 0,      0, 0, 0, 0,      0, 0, 0);
    tv[12] = v(0, 0,      0, 1, 'h1111, 0, 0,   0, 0,      0, 0, 1, 'h1111, 1, 0, 0);
    tv[13] = v(0, 0,      0, 1, 'h2222, 1, 0,   0, 0,      0, 0, 1, 'h2222, 1, 0, 0);
    tv[14] = v(0, 0,      0, 0, 0,      1, 0,   0, 0,      0, 0, 0, 0,      0, 0, 0);
    tv[15] = v(0, 0,      0, 0, 0,      1, 0,   0, 0,      0, 0, 0, 0,      0, 0, 1);
    tv[16] = v(0, 0,      0, 0, 0,      0, 1,   0, 0,      0, 0, 0, 0,      0, 0, 0);

    for (int i = 0; i < 17; i++) begin
      wr_en = tv[i].wr; wr_data = tv[i].wd; pop = tv[i].pp;
      push = tv[i].ps; D_push = tv[i].dp; rx_rd = tv[i].rd;
      err_clr = tv[i].clr;
      tick();
      chk($sformatf("v%0d_pndng", i), pndng, tv[i].e_pnd);
      chk($sformatf("v%0d_dpop", i), D_pop, tv[i].e_dpop);
      chk($sformatf("v%0d_tcnt", i), tx_cnt, tv[i].e_tcnt);
      chk($sformatf("v%0d_full", i), tx_full, tv[i].e_full);
      chk($sformatf("v%0d_rvld", i), rx_vld, tv[i].e_rvld);
      chk($sformatf("v%0d_rdata", i), rx_data, tv[i].e_rdat);
      chk($sformatf("v%0d_rcnt", i), rx_cnt, tv[i].e_rcnt);
      chk($sformatf("v%0d_ovf", i), ovf, tv[i].e_ovf);
      chk($sformatf("v%0d_udf", i), udf, tv[i].e_udf);
    end
    idle();

    // TX full boundary
    for (int i = 0; i < 8; i++) begin
      wr_en = 1; wr_data = PW'(16'h0010 + i);
      tick();
    end
    idle();
    chk("full_flag", tx_full, 1);
    chk("full_cnt", tx_cnt, 8);
    chk("full_head", D_pop, 16'h0010);
    wr_en = 1; wr_data = 16'h00FF;
    tick();
    idle();
    chk("drop_cnt", tx_cnt, 8);
    chk("drop_ovf", ovf, 1);
    chk("drop_head", D_pop, 16'h0010);
    err_clr = 1;
    tick();
    idle();
    chk("ovf_clr", ovf, 0);
    wr_en = 1; wr_data = 16'h0099; pop = 1;
    tick();
    idle();
    chk("wrpop_cnt", tx_cnt, 8);
    chk("wrpop_full", tx_full, 1);
    chk("wrpop_ovf", ovf, 0);
    for (int i = 0; i < 8; i++) begin
      exp_d = (i == 7) ? 16'h0099 : PW'(16'h0011 + i);
      chk($sformatf("drain%0d", i), D_pop, exp_d);
      pop = 1;
      tick();
    end
    idle();
    chk("drain_pndng", pndng, 0);
    chk("drain_cnt", tx_cnt, 0);

    // RX interleaved traffic across pointer wrap
    q.delete();
    for (int i = 0; i < 20; i++) begin
      push = 1; D_push = PW'(16'h2000 + i);
      rx_rd = (q.size() >= 3);
      if (rx_rd) void'(q.pop_front());
      q.push_back(D_push);
      tick();
      chk($sformatf("rxw%0d_data", i), rx_data, q[0]);
      chk($sformatf("rxw%0d_cnt", i), rx_cnt, CW'(q.size()));
    end
    idle();
    while (q.size() > 0) begin
      chk("rxd_data", rx_data, q[0]);
      void'(q.pop_front());
      rx_rd = 1;
      tick();
    end
    idle();
    chk("rxd_vld", rx_vld, 0);

    for (int i = 0; i < 8; i++) begin
      push = 1; D_push = PW'(16'h3000 + i);
      tick();
    end
    push = 1; D_push = 16'h3FFF;
    tick();
    idle();
    chk("rxovf_cnt", rx_cnt, 8);
    chk("rxovf_flag", ovf, 1);
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("rxf%0d", i), rx_data, PW'(16'h3000 + i));
      rx_rd = 1;
      tick();
    end
    idle();
    chk("rxf_empty", rx_cnt, 0);
    err_clr = 1;
    tick();
    idle();
    chk("clr_all", {ovf, udf, id_err}, 0);

    // Destination ID check
    pk.id = 8'h03; pk.payload = 8'hAA;
    push = 1; D_push = pk;
    tick();
    idle();
    chk("id_match", id_err, 0);
    pk.id = 8'h05;
    push = 1; D_push = pk;
    tick();
    idle();
`ifdef BUS_TERM_ID_CHECK_EN
    chk("id_mismatch", id_err, 1);
`else
    chk("id_tied", id_err, 0);
`endif
    chk("id_head", rx_data, 16'h03AA);
    rx_rd = 1;
    tick();
    idle();
    chk("id_stored", rx_data, 16'h05AA);
    rx_rd = 1;
    tick();
    idle();

    // Asynchronous reset mid-operation
    for (int i = 0; i < 3; i++) begin
      wr_en = 1; wr_data = PW'(16'h4000 + i);
      push = 1; D_push = PW'(16'h5000 + i);
      tick();
    end
    idle();
    chk("pre_rst_cnt", tx_cnt, 3);
    @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    chk("arst_pndng", pndng, 0);
    chk("arst_dpop", D_pop, 0);
    chk("arst_tcnt", tx_cnt, 0);
    chk("arst_rvld", rx_vld, 0);
    chk("arst_rcnt", rx_cnt, 0);
    chk("arst_id", id_err, 0);
    @(negedge clk);
    reset = 1'b0;
    wr_en = 1; wr_data = 16'h4242;
    tick();
    idle();
    chk("post_rst_dpop", D_pop, 16'h4242);
    chk("post_rst_cnt", tx_cnt, 1);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/bus_term_fifo.md
Name: bus_term_fifo

Overview:
- Per-terminal buffer sitting between the host/agent side and one port of the bus generator/arbiter (`bs_gnrtr_n_rbtr`).
- TX queue: holds packets the terminal wants to send. The bus side sees `pndng`/`D_pop` and dequeues with `pop`.
- RX queue: captures packets the bus delivers via `push`/`D_push`. The host drains them with `rx_rd`.
- One instance per driver; the top level instantiates DRVS copies.

Parameters:
- PCKG_SZ, 16, packet width in bits; the destination ID is in bits [PCKG_SZ-1 -: ID_W].
- DEPTH, 8, entries per queue; must be a power of 2 and ≥ 2.
- ID_W, 8, width of the destination-ID field.
- TERM_ID, 0, this terminal's ID; used only with ID_CHECK_EN.

Ports:
- clk  in  1  clock, all logic rising-edge.
- reset  in  1  asynchronous, active-high; clears all state.
- wr_en  in  1  host write strobe into the TX queue.
- wr_data  in  PCKG_SZ  packet to enqueue.
- tx_full  out  1  TX queue holds DEPTH entries.
- tx_cnt  out  $clog2(DEPTH+1)  TX occupancy.
- pndng  out  1  TX queue non-empty (to bus).
- D_pop  out  PCKG_SZ  TX head, first-word fall-through (to bus).
- pop  in  1  bus dequeues TX head.
- push  in  1  bus delivers a packet.
- D_push  in  PCKG_SZ  delivered packet.
- rx_rd  in  1  host dequeues RX head.
- rx_data  out  PCKG_SZ  RX head, first-word fall-through.
- rx_vld  out  1  RX queue non-empty.
- rx_cnt  out  $clog2(DEPTH+1)  RX occupancy.
- ovf  out  1  sticky: write attempted while the target queue was full.
- udf  out  1  sticky: pop or rx_rd attempted while the queue was empty.
- id_err  out  1  sticky: a received packet's ID ≠ TERM_ID (ID_CHECK_EN only).
- err_clr  in  1  synchronous clear of ovf/udf/id_err.

Behaviour:
- **Reset:** on reset=1, all pointers and counts go to 0 and every output goes to 0 (pndng, D_pop, tx_full, rx_vld, rx_data, flags), independent of clk.
- **Read data:** D_pop and rx_data are combinational from storage at the read pointer. They are forced to 0 when the queue is empty.
- **Latency:**
  - A write on cycle N is visible on pndng/D_pop (TX) or rx_vld/rx_data (RX) after edge N+1.
  - A pop on cycle N advances the head at edge N+1.
- **TX write rule:** the write is accepted iff wr_en && (!tx_full || pop). Simultaneous write and pop while full is accepted and occupancy stays at DEPTH.
- **TX overflow:** wr_en while full with no pop → write dropped, ovf←1.
- **TX underflow:** pop while empty → ignored, udf←1, pointers unchanged.
- **Simultaneous events when empty:** wr_en && pop → pop counts as underflow, write accepted, tx_cnt=1.
- **RX queue:** identical rules, with push/D_push as the write and rx_rd as the read. A push while full is dropped and sets ovf.
- **Pointers:** log2(DEPTH)-bit, wrap naturally modulo DEPTH. Count is a separate register: +1 on accepted write only, −1 on valid read only, unchanged on both.
- **Flags:** sticky until err_clr. If err_clr and a new error occur in the same cycle, the flag is set (set wins).
- **Reset mid-operation:** queued data is lost and the queues restart empty. No partial state survives.

Optional Feature:
- **Macro:** BUS_TERM_ID_CHECK_EN.
- **Defined:** each accepted push compares D_push[PCKG_SZ-1 -: ID_W] with TERM_ID; a mismatch sets id_err. The packet is still stored.
- **Undefined:** no comparator is built and id_err is tied to 0.

Decomposition:
- **Package bus_term_pkg:** the packet typedef (struct of id[ID_W] and payload[PCKG_SZ-ID_W]), the default constants, and the cnt width function.
- **Sub-module sync_fwft_fifo:** parameterised storage, pointers, count, and full/empty logic, plus ovf/udf pulse outputs. Instantiated twice (TX, RX); the top level holds the sticky flags and the ID check.

Test Plan:
- **Reset:** write 3 packets, assert reset asynchronously mid-cycle → pndng=0, D_pop=0, tx_cnt=0 immediately; rx_vld=0.
- **TX FIFO order:** write 0x0101, 0x0202, 0x0303 → D_pop shows 0x0101 one cycle later; three pops yield 0x0101, 0x0202, 0x0303; pndng falls after the third.
- **Full boundary:** write 8 packets → tx_full=1, tx_cnt=8. A 9th write alone → dropped, ovf=1. A 9th write with pop → accepted, tx_cnt stays 8, order preserved.
- **Underflow and clear:** pop on empty → udf=1, tx_cnt=0; err_clr → udf=0. err_clr plus a new pop on empty → udf remains 1.
- **RX path with wrap-around:** 20 pushes interleaved with rx_rd, occupancy never >8 → rx_data order matches across pointer wrap; push when rx_cnt=8 → dropped, ovf=1.
- **ID check:** with BUS_TERM_ID_CHECK_EN and TERM_ID=3, push 0x03AA → id_err=0; push 0x05AA → id_err=1 and the packet is still readable on rx_data.
